led_trail_pwm: RTL and testbench

Downstream consumer of the bouncing one-hot shift register. Turns its one-hot position vector into a fading LED trail: each LED's brightness is set to full when the '1' passes and decays on every shift step. Brightness is rendered by a free-running PWM. A sweep flash of all LEDs can follow each terminal-count pulse. It drives the board LED pins directly.

---
 rtl/led_trail_pwm_pkg.sv | 31 +++
 rtl/led_trail_pwm_if.sv | 36 +++
 rtl/led_trail_pwm_trail_channel.sv | 67 ++++++
 rtl/led_trail_pwm.sv | 113 +++++++++++
 tb/tb_led_trail_pwm.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/led_trail_pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_trail_pwm_pkg
//  Description : Shared types and constants for the LED trail PWM block.
//                Holds the RUN/FLASH state encoding, the full-scale level
//                derived from the brightness width, and the flash frame
//                counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package led_trail_pwm_pkg;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLASH = 1'b1
   } state_e;

   // Full-scale brightness for a BW-bit level; also the PWM frame length.
   function automatic int pwm_max(input int bw);
      return (1 << bw) - 1;
   endfunction

   // A single-frame flash still needs one counter bit to stay legal.
   function automatic int flash_cnt_w(input int frames);
      return (frames > 1) ? $clog2(frames) : 1;
   endfunction

   localparam int DEF_BW           = 4;
   localparam int DEF_FLASH_FRAMES = 2;

endpackage
`default_nettype wire

// File: rtl/led_trail_pwm_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_trail_pwm_if
//  Description : Signal bundle between the shift register / board and the
//                LED trail PWM block.
//                  step        shift strobe
//                  q_in        one-hot position vector
//                  tc_in       terminal-count pulse
//                  flash_en    allows tc_in to start a flash
//                  led         registered LED drive
//                  frame_start one-cycle pulse per PWM frame wrap
//                  flashing    high while a flash is in progress
//  Revision    : 1.0  initial release
// ============================================================================
interface led_trail_pwm_if #(
   parameter int N = 8
);
   logic         step;
   logic [N-1:0] q_in;
   logic         tc_in;
   logic         flash_en;
   logic [N-1:0] led;
   logic         frame_start;
   logic         flashing;

   modport master (
      output step, q_in, tc_in, flash_en,
      input  led, frame_start, flashing
   );

   modport slave (
      input  step, q_in, tc_in, flash_en,
      output led, frame_start, flashing
   );
endinterface
`default_nettype wire

// File: rtl/led_trail_pwm_trail_channel.sv
`default_nettype none
// ============================================================================
//  Module      : trail_channel
//  Description : One LED of the trail. The shadow level is reloaded to full
//                when the position bit passes and decays by DECAY per step,
//                saturating at zero. The active level is the copy the PWM
//                compare uses; it is refreshed only at frame wraps so a
//                frame never shows a torn duty cycle.
//  Ports       : clk, rstna        clock, async active-low reset
//                step_i            shift strobe
//                hit_i             this LED's bit of the position vector
//                wrap_i            PWM frame wrap on this edge
//                pwm_cnt_i         current PWM count
//                lit_o             combinational compare, active > count
//  Revision    : 1.0  initial release
// ============================================================================
module trail_channel
   import led_trail_pwm_pkg::*;
#(
   parameter int BW    = DEF_BW,
   parameter int DECAY = 4
) (
   input  wire logic          clk,
   input  wire logic          rstna,
   input  wire logic          step_i,
   input  wire logic          hit_i,
   input  wire logic          wrap_i,
   input  wire logic [BW-1:0] pwm_cnt_i,
   output logic               lit_o
);
   localparam logic [BW-1:0] C_FULL  = BW'(pwm_max(BW));
   localparam logic [BW-1:0] C_DECAY = BW'(DECAY);

   logic [BW-1:0] shadow_q, shadow_d;
   logic [BW-1:0] active_q, active_d;

   always_comb begin
      shadow_d = shadow_q;
      if (step_i) begin
         if (hit_i)
            shadow_d = C_FULL;
         else if (shadow_q >= C_DECAY)
            shadow_d = shadow_q - C_DECAY;
         else
            shadow_d = '0;
      end
   end

   // The pre-edge shadow is taken, so a step landing on the wrap edge
   // only becomes visible one frame later.
   assign active_d = wrap_i ? shadow_q : active_q;

   always_ff @(posedge clk or negedge rstna) begin
      if (!rstna) begin
         shadow_q <= '0;
         active_q <= '0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   // Count tops out at full-scale minus one, so full scale is always on.
   assign lit_o = (active_q > pwm_cnt_i);

endmodule
`default_nettype wire

// File: rtl/led_trail_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : led_trail_pwm
//  Description : Fading LED trail driven by a one-hot shift register. Holds
//                the free-running PWM counter, the RUN/FLASH state machine,
//                the frame_start pulse and the registered output mux. The
//                per-LED level handling lives in trail_channel.
//  Ports       : clk       system clock
//                rstna     asynchronous active-low reset
//                bus       led_trail_pwm_if slave (step, q_in, tc_in,
//                          flash_en in; led, frame_start, flashing out)
//  Revision    : 1.0  initial release
// ============================================================================
module led_trail_pwm
   import led_trail_pwm_pkg::*;
#(
   parameter int N            = 8,
   parameter int BW           = DEF_BW,
   parameter int DECAY        = 4,
   parameter int FLASH_FRAMES = DEF_FLASH_FRAMES
) (
   input  wire logic     clk,
   input  wire logic     rstna,
   led_trail_pwm_if.slave bus
);
   localparam int              PWM_MAX      = pwm_max(BW);
   localparam int              FCW          = flash_cnt_w(FLASH_FRAMES);
   localparam logic [BW-1:0]   C_CNT_LAST   = BW'(PWM_MAX - 1);
   localparam logic [FCW-1:0]  C_FLASH_LAST = FCW'(FLASH_FRAMES - 1);

   logic [BW-1:0]  pwm_cnt_q, pwm_cnt_d;
   logic           wrap;
   state_e         state_q;
   logic [FCW-1:0] flash_cnt_q;
   logic           flashing_q;
   logic           frame_start_q;
   logic [N-1:0]   led_q, led_d;
   logic [N-1:0]   lit;

   assign wrap      = (pwm_cnt_q == C_CNT_LAST);
   assign pwm_cnt_d = wrap ? '0 : pwm_cnt_q + 1'b1;

   always_ff @(posedge clk or negedge rstna) begin
      if (!rstna) begin
         pwm_cnt_q     <= '0;
         frame_start_q <= 1'b0;
      end else begin
         pwm_cnt_q     <= pwm_cnt_d;
         frame_start_q <= wrap;
      end
   end

   generate
      for (genvar i = 0; i < N; i++) begin : g_chan
         trail_channel #(
            .BW    (BW),
            .DECAY (DECAY)
         ) u_chan (
            .clk       (clk),
            .rstna     (rstna),
            .step_i    (bus.step),
            .hit_i     (bus.q_in[i]),
            .wrap_i    (wrap),
            .pwm_cnt_i (pwm_cnt_q),
            .lit_o     (lit[i])
         );
      end
   endgenerate

   // tc_in is not looked at in FLASH, which makes the flash non-retriggerable;
   // flash_en is only sampled at entry, so dropping it cannot abort a flash.
   always_ff @(posedge clk or negedge rstna) begin
      if (!rstna) begin
         state_q     <= ST_RUN;
         flash_cnt_q <= '0;
         flashing_q  <= 1'b0;
      end else begin
         flashing_q <= (state_q == ST_FLASH);
         case (state_q)
            ST_RUN: begin
               if (bus.tc_in && bus.flash_en) begin
                  state_q     <= ST_FLASH;
                  flash_cnt_q <= '0;
               end
            end
            ST_FLASH: begin
               if (wrap) begin
                  if (flash_cnt_q == C_FLASH_LAST)
                     state_q <= ST_RUN;
                  else
                     flash_cnt_q <= flash_cnt_q + 1'b1;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign led_d = (state_q == ST_FLASH) ? '1 : lit;

   always_ff @(posedge clk or negedge rstna) begin
      if (!rstna)
         led_q <= '0;
      else
         led_q <= led_d;
   end

   assign bus.led         = led_q;
   assign bus.frame_start = frame_start_q;
   assign bus.flashing    = flashing_q;

endmodule
`default_nettype wire

// File: tb/tb_led_trail_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_trail_pwm
//  Description : Self-checking bench for led_trail_pwm. A behavioural model
//                (integer levels, frame phase, flash frame count) predicts
//                led/frame_start/flashing every cycle; directed scenarios
//                add duty-cycle and duration counts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_trail_pwm;
   import led_trail_pwm_pkg::*;

   localparam int N     = 8;
   localparam int BW    = 4;
   localparam int DECAY = 4;
   localparam int FF    = 2;
   localparam int PM    = 15;

   logic clk   = 1'b0;
   logic rstna = 1'b1;
   always #5 clk = ~clk;

   led_trail_pwm_if #(.N(N)) bus ();

   led_trail_pwm #(
      .N            (N),
      .BW           (BW),
      .DECAY        (DECAY),
      .FLASH_FRAMES (FF)
   ) dut (
      .clk   (clk),
      .rstna (rstna),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int           m_lvl_next[N];   // level decided by the most recent steps
   int           m_lvl_show[N];   // level the current frame displays
   int           m_phase;         // position inside the 15-cycle frame
   bit           m_flash;
   int           m_frames_done;
   logic [N-1:0] e_led;
   logic         e_fs;
   logic         e_fl;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_lvl_next[i] = 0;
         m_lvl_show[i] = 0;
      end
      m_phase       = 0;
      m_flash       = 0;
      m_frames_done = 0;
      e_led         = '0;
      e_fs          = 1'b0;
      e_fl          = 1'b0;
   endtask

   task automatic model_step(input bit st, input logic [N-1:0] q, input bit tc, input bit en);
      bit frame_end;
      frame_end = (m_phase == PM - 1);
      // LED i is on during the first lvl cycles of the frame.
      for (int i = 0; i < N; i++)
         e_led[i] = m_flash ? 1'b1 : (m_phase < m_lvl_show[i]);
      e_fl = m_flash;
      e_fs = frame_end;
      if (frame_end)
         for (int i = 0; i < N; i++) m_lvl_show[i] = m_lvl_next[i];
      if (st)
         for (int i = 0; i < N; i++)
            m_lvl_next[i] = q[i] ? PM : ((m_lvl_next[i] > DECAY) ? m_lvl_next[i] - DECAY : 0);
      if (!m_flash) begin
         if (tc && en) begin
            m_flash       = 1;
            m_frames_done = 0;
         end
      end else if (frame_end) begin
         m_frames_done++;
         if (m_frames_done == FF) m_flash = 0;
      end
      m_phase = (m_phase + 1) % PM;
   endtask

   task automatic run_cycle(input bit rn, input bit st, input logic [N-1:0] q,
                            input bit tc, input bit en);
      @(negedge clk);
      rstna        = rn;
      bus.step     = st;
      bus.q_in     = q;
      bus.tc_in    = tc;
      bus.flash_en = en;
      @(posedge clk);
      if (!rn) model_reset();
      else     model_step(st, q, tc, en);
      #1;
      chk("led", 32'(bus.led), 32'(e_led));
      chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
      chk("flashing", 32'(bus.flashing), 32'(e_fl));
   endtask

   task automatic idle();
      run_cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic wait_wrap();
      bit seen;
      seen = 0;
      for (int k = 0; k < PM + 2; k++) begin
         if (!seen) begin
            idle();
            if (e_fs) seen = 1;
         end
      end
      if (!seen) chk("wrap_timeout", 32'd0, 32'd1);
   endtask

   // Leaves the model so that the next clock edge is a frame wrap.
   task automatic align_last();
      for (int k = 0; k < PM + 2; k++)
         if (m_phase != PM - 1) idle();
   endtask

   task automatic count_frame(input int b, output int cnt);
      cnt = 0;
      for (int k = 0; k < PM; k++) begin
         idle();
         cnt += int'(bus.led[b]);
      end
   endtask

   int c, c2, first;
   logic [N-1:0] rq;

   initial begin
      bus.step = 1'b0; bus.q_in = '0; bus.tc_in = 1'b0; bus.flash_en = 1'b0;
      model_reset();

      // Reset state
      #2 rstna = 1'b0;
      #1;
      chk("rst_led", 32'(bus.led), 32'h0);
      chk("rst_flashing", 32'(bus.flashing), 32'h0);
      chk("rst_fs", 32'(bus.frame_start), 32'h0);
      repeat (3) run_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);

      // Two idle frames: LEDs dark, one frame_start per 15 cycles
      c = 0;
      for (int k = 0; k < 2 * PM; k++) begin
         idle();
         c += int'(bus.frame_start);
      end
      chk("idle_fs_count", 32'(c), 32'd2);
      chk("idle_led", 32'(bus.led), 32'h0);

      // Full level and decay on LED 7
      run_cycle(1'b1, 1'b1, 8'h80, 1'b0, 1'b0);
      wait_wrap();
      count_frame(7, c);
      chk("full_level_on_cycles", 32'(c), 32'd15);
      run_cycle(1'b1, 1'b1, 8'h40, 1'b0, 1'b0);
      wait_wrap();
      count_frame(7, c);
      chk("decay_level11", 32'(c), 32'd11);
      run_cycle(1'b1, 1'b1, 8'h40, 1'b0, 1'b0);
      wait_wrap();
      count_frame(7, c);
      chk("decay_level7", 32'(c), 32'd7);
      run_cycle(1'b1, 1'b1, 8'h40, 1'b0, 1'b0);
      wait_wrap();
      count_frame(7, c);
      chk("decay_level3", 32'(c), 32'd3);
      run_cycle(1'b1, 1'b1, 8'h40, 1'b0, 1'b0);
      run_cycle(1'b1, 1'b1, 8'h40, 1'b0, 1'b0);
      wait_wrap();
      count_frame(7, c);
      chk("decay_saturates_0", 32'(c), 32'd0);

      // Step coinciding with the wrap edge
      align_last();
      run_cycle(1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
      count_frame(0, c);
      count_frame(0, c2);
      chk("coincide_frame0", 32'(c), 32'd0);
      chk("coincide_frame1", 32'(c2), 32'd15);

      // Flash: 2 frames, retrigger ignored, flash_en drop ignored
      align_last();
      run_cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
      c = 0; c2 = 0;
      for (int k = 0; k < 32; k++) begin
         run_cycle(1'b1, 1'b0, '0, (k == 9), (k < 15));
         c  += int'(bus.flashing);
         c2 += int'(bus.led == 8'hFF);
      end
      chk("flash_cycles", 32'(c), 32'd30);
      chk("flash_led_all_on", 32'(c2), 32'd30);

      // Async reset in the middle of a flash at pwm_cnt = 7
      run_cycle(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
      run_cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
      for (int k = 0; k < PM + 2; k++)
         if (m_phase != 7) idle();
      chk("pre_rst_cnt", 32'(dut.pwm_cnt_q), 32'd7);
      chk("pre_rst_flashing", 32'(bus.flashing), 32'd1);
      #2 rstna = 1'b0;
      #1;
      chk("async_led", 32'(bus.led), 32'h0);
      chk("async_flashing", 32'(bus.flashing), 32'h0);
      chk("async_state", 32'(dut.state_q), 32'(ST_RUN));
      chk("async_cnt", 32'(dut.pwm_cnt_q), 32'h0);
      model_reset();
      run_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
      first = 0;
      for (int k = 1; k <= 20; k++) begin
         idle();
         if (bus.frame_start === 1'b1 && first == 0) first = k;
      end
      chk("first_fs_after_rst", 32'(first), 32'd15);

      // Randomized traffic against the model
      for (int k = 0; k < 1500; k++) begin
         rq = '0;
         rq[$urandom_range(N - 1)] = 1'b1;
         if ($urandom_range(7) == 0) rq = N'($urandom);
         run_cycle(1'b1, ($urandom_range(2) == 0), rq,
                   ($urandom_range(39) == 0), ($urandom_range(1) == 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
